ysyx_23060208_ifu_fetch: RTL and testbench
==========================================

YSYX_23060208_IFU_FETCH -- requirements
Module: ysyx_23060208_IFU_FETCH

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter RESP_W, default 2, meaning memory response code width (0 = OKAY).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port pc, input, DATA_WIDTH, the current PC from the PC register.
REQ-006 SHALL have port fetch_en, input, 1, a pulse meaning the PC has been updated and the next fetch may start.
REQ-007 SHALL have port araddr, output, DATA_WIDTH, the read address to instruction memory.
REQ-008 SHALL have port arvalid, output, 1, the read-address request valid.
REQ-009 SHALL have port arready, input, 1, the read-address accept from memory.
REQ-010 SHALL have port rdata, input, DATA_WIDTH, the read data from memory.
REQ-011 SHALL have port rresp, input, RESP_W, the read response code.
REQ-012 SHALL have port rvalid, input, 1, the read data valid.
REQ-013 SHALL have port rready, output, 1, meaning the fetch unit is able to accept read data.
REQ-014 SHALL have port inst, output, DATA_WIDTH, the fetched instruction to decode.
REQ-015 SHALL have port inst_pc, output, DATA_WIDTH, the PC of inst.
REQ-016 SHALL have port inst_err, output, 1, meaning the fetch faulted (bad response or misaligned PC).
REQ-017 SHALL have port inst_valid, output, 1, meaning inst, inst_pc and inst_err are valid.
REQ-018 SHALL have port inst_ready, input, 1, the decode-stage accept.

Function
REQ-019 SHALL implement the states IDLE, AR, R, OUT and WAIT.
REQ-020 IDLE: SHALL move to AR on the first cycle after reset deassertion (boot fetch), without requiring fetch_en.
REQ-021 On entering AR, SHALL latch pc into the address/inst_pc register; araddr SHALL be driven from that register, not from the live pc.
REQ-022 AR: arvalid=1, and araddr SHALL be held stable until arready; on arvalid&&arready, SHALL go to R.
REQ-023 If the latched pc[1:0]!=0, SHALL skip AR/R: arvalid is never raised, and the state goes to OUT with inst=0, inst_err=1.
REQ-024 R: rready=1; on rvalid, SHALL capture rdata into inst, set inst_err=(rresp!=0), and go to OUT.
REQ-025 OUT: inst_valid=1, with inst, inst_pc and inst_err stable until inst_ready; on inst_valid&&inst_ready, SHALL go to WAIT.
REQ-026 WAIT: on fetch_en (or a pending flag set), SHALL go to AR the next cycle, latching the updated pc.
REQ-027 A fetch_en arriving in AR/R/OUT SHALL set the pending flag, which is cleared on entering AR; multiple pulses SHALL collapse into one.
REQ-028 The minimum latency, with arready and rvalid same-cycle, SHALL be: fetch_en at t -> arvalid at t+1 -> rready/rvalid at t+2 -> inst_valid at t+3.
REQ-029 In states other than AR, arvalid SHALL be 0; in states other than R, rready SHALL be 0; outside OUT, inst_valid SHALL be 0.
REQ-030 rvalid seen outside R SHALL be ignored, with no state change.
REQ-031 At most one read SHALL be outstanding; no new AR SHALL be issued before the R beat completes.

Reset
REQ-032 rst SHALL force state IDLE, arvalid=0, rready=0, inst_valid=0, inst=0, inst_pc=0, inst_err=0, araddr=0 and pending=0, in the same edge.
REQ-033 A reset during AR/R/OUT SHALL abandon the transaction; a late rvalid after reset SHALL be ignored (see REQ-030), and the boot fetch SHALL restart per REQ-020.

Structure
REQ-034 The state encoding (3-bit) and the RESP OKAY constant SHALL live in the shared ysyx_23060208 package/define file.
REQ-035 The block SHALL be a single module with no sub-module; the state register, address register, instruction register and pending flag SHALL be local.

Verification
REQ-036 Boot: pc=0x80000000, arready=1 always, rvalid one cycle after AR with rdata=0x00000413 -> araddr=0x80000000 at cycle 1, inst_valid at cycle 3 with inst=0x00000413, inst_pc=0x80000000.
REQ-037 Backpressure: arready low for 3 cycles, inst_ready low for 2 cycles -> araddr/arvalid held stable, inst held stable, exactly one transfer each.
REQ-038 Error: rresp=2 with rdata=0xDEADBEEF -> inst_valid with inst_err=1, inst=0xDEADBEEF.
REQ-039 Misaligned: pc=0x80000002 after fetch_en -> arvalid never asserts, inst_valid with inst_err=1, inst=0.
REQ-040 Early fetch_en: two fetch_en pulses during R -> exactly one subsequent AR, to the pc value present on entering AR.
REQ-041 Reset in R: rst asserted for 1 cycle while in R, then rvalid pulsed -> rvalid ignored, next araddr equals current pc, inst_valid stays 0 until the new read completes.

Source files
------------

// File: rtl/ysyx_23060208_ifu_fetch_pkg.sv
// Shared definitions for the ysyx_23060208 instruction fetch unit:
// the 3-bit state encoding, the OKAY response code and a small alignment helper.
package ysyx_23060208_ifu_fetch_pkg;

   // Fetch FSM state encoding (3 bits; kept as plain constants for legacy users)
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_AR   = 3'd1;
   localparam logic [2:0] ST_R    = 3'd2;
   localparam logic [2:0] ST_OUT  = 3'd3;
   localparam logic [2:0] ST_WAIT = 3'd4;

   // Memory read response code meaning a successful access
   localparam int RESP_OKAY = 0;

   // True when a byte address is not word aligned
   function automatic logic is_misaligned(input logic [1:0] addr_lo);
      return addr_lo != 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch unit: issues one read per fetch on an AXI-lite style
// read channel, hands the instruction to decode with a valid/ready handshake,
// and remembers fetch_en pulses that arrive while a fetch is in flight.
module ysyx_23060208_ifu_fetch
   import ysyx_23060208_ifu_fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RESP_W     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic                  fetch_en,
   output logic [DATA_WIDTH-1:0] araddr,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [RESP_W-1:0]     rresp,
   input  logic                  rvalid,
   output logic                  rready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [DATA_WIDTH-1:0] inst_pc,
   output logic                  inst_err,
   output logic                  inst_valid,
   input  logic                  inst_ready
);

   logic [2:0]            state_q;
   logic [2:0]            state_d;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] inst_q;
   logic                  err_q;
   logic                  pending_q;
   logic                  start_fetch;
   logic                  pc_misaligned;
   logic                  in_flight;

   assign pc_misaligned = is_misaligned(pc[1:0]);
   assign in_flight     = (state_q == ST_AR) || (state_q == ST_R) || (state_q == ST_OUT);

   // Next-state logic; a new fetch either goes to AR or, for a misaligned pc,
   // straight to OUT so that no bus request is ever issued for it
   always_comb begin
      state_d     = state_q;
      start_fetch = 1'b0;
      case (state_q)
         ST_IDLE: start_fetch = 1'b1;
         ST_AR:   if (arready) state_d = ST_R;
         ST_R:    if (rvalid) state_d = ST_OUT;
         ST_OUT:  if (inst_ready) state_d = ST_WAIT;
         ST_WAIT: if (fetch_en || pending_q) start_fetch = 1'b1;
         default: state_d = ST_IDLE;
      endcase
      if (start_fetch) begin
         state_d = pc_misaligned ? ST_OUT : ST_AR;
      end
   end

   // State, address/inst_pc, instruction, error and pending-fetch registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         inst_q    <= '0;
         err_q     <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_fetch) begin
            addr_q    <= pc;
            pending_q <= 1'b0;
            if (pc_misaligned) begin
               inst_q <= '0;
               err_q  <= 1'b1;
            end
         end else if (fetch_en && in_flight) begin
            pending_q <= 1'b1;
         end
         if ((state_q == ST_R) && rvalid) begin
            inst_q <= rdata;
            err_q  <= (rresp != RESP_W'(RESP_OKAY));
         end
      end
   end

   assign araddr     = addr_q;
   assign inst_pc    = addr_q;
   assign inst       = inst_q;
   assign inst_err   = err_q;
   assign arvalid    = (state_q == ST_AR);
   assign rready     = (state_q == ST_R);
   assign inst_valid = (state_q == ST_OUT);

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// Directed testbench for the ysyx_23060208 fetch unit: boot fetch, bus and
// decode backpressure, error response, misaligned pc, collapsed early
// fetch_en pulses and a reset in the middle of a read.
module tb_ysyx_23060208_ifu_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        fetch_en;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_err;
   logic        inst_valid;
   logic        inst_ready;

   int num_checks = 0;
   int num_errors = 0;
   int ar_count   = 0;
   int out_count  = 0;

   ysyx_23060208_ifu_fetch #(.DATA_WIDTH(32), .RESP_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .fetch_en   (fetch_en),
      .araddr     (araddr),
      .arvalid    (arvalid),
      .arready    (arready),
      .rdata      (rdata),
      .rresp      (rresp),
      .rvalid     (rvalid),
      .rready     (rready),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_err   (inst_err),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count completed address and decode handshakes
   always @(posedge clk) begin
      if (!rst && arvalid && arready) ar_count <= ar_count + 1;
      if (!rst && inst_valid && inst_ready) out_count <= out_count + 1;
   end

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive every input, then advance to the next falling edge
   task automatic applyStimulus(input logic r, input logic [31:0] p, input logic fe, input logic ar,
                                input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                                input logic ir);
      rst        = r;
      pc         = p;
      fetch_en   = fe;
      arready    = ar;
      rvalid     = rv;
      rdata      = rd;
      rresp      = rr;
      inst_ready = ir;
      @(negedge clk);
   endtask

   initial begin
      int a0;
      int o0;

      // Reset
      applyStimulus(1, 32'h8000_0000, 0, 1, 0, 0, 0, 0);
      applyStimulus(1, 32'h8000_0000, 0, 1, 0, 0, 0, 0);
      checkOutput("rst_arvalid", 32'(arvalid), 0);
      checkOutput("rst_rready", 32'(rready), 0);
      checkOutput("rst_inst_valid", 32'(inst_valid), 0);
      checkOutput("rst_araddr", araddr, 0);
      checkOutput("rst_inst", inst, 0);
      checkOutput("rst_inst_pc", inst_pc, 0);
      checkOutput("rst_inst_err", 32'(inst_err), 0);

      // Boot fetch without fetch_en
      applyStimulus(0, 32'h8000_0000, 0, 1, 0, 0, 0, 0);
      checkOutput("boot_arvalid", 32'(arvalid), 1);
      checkOutput("boot_araddr", araddr, 32'h8000_0000);
      checkOutput("boot_rready_ar", 32'(rready), 0);
      applyStimulus(0, 32'h8000_0000, 0, 1, 0, 0, 0, 0);
      checkOutput("boot_rready", 32'(rready), 1);
      checkOutput("boot_arvalid_r", 32'(arvalid), 0);
      applyStimulus(0, 32'h8000_0000, 0, 1, 1, 32'h0000_0413, 0, 0);
      checkOutput("boot_inst_valid", 32'(inst_valid), 1);
      checkOutput("boot_inst", inst, 32'h0000_0413);
      checkOutput("boot_inst_pc", inst_pc, 32'h8000_0000);
      checkOutput("boot_inst_err", 32'(inst_err), 0);
      checkOutput("boot_rready_out", 32'(rready), 0);
      applyStimulus(0, 32'h8000_0000, 0, 1, 0, 0, 0, 1);
      checkOutput("boot_wait_valid", 32'(inst_valid), 0);
      checkOutput("boot_wait_arvalid", 32'(arvalid), 0);
      checkOutput("boot_ar_count", 32'(ar_count), 1);
      checkOutput("boot_out_count", 32'(out_count), 1);

      // Backpressure on address and decode side
      a0 = ar_count;
      o0 = out_count;
      applyStimulus(0, 32'h8000_0004, 1, 0, 0, 0, 0, 0);
      checkOutput("bp_arvalid", 32'(arvalid), 1);
      checkOutput("bp_araddr", araddr, 32'h8000_0004);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 32'h8000_0100, 0, 0, 0, 0, 0, 0);
         checkOutput("bp_arvalid_hold", 32'(arvalid), 1);
         checkOutput("bp_araddr_hold", araddr, 32'h8000_0004);
      end
      applyStimulus(0, 32'h8000_0100, 0, 1, 0, 0, 0, 0);
      checkOutput("bp_rready", 32'(rready), 1);
      checkOutput("bp_arvalid_r", 32'(arvalid), 0);
      applyStimulus(0, 32'h8000_0100, 0, 0, 1, 32'h0010_0093, 0, 0);
      checkOutput("bp_inst_valid", 32'(inst_valid), 1);
      checkOutput("bp_inst", inst, 32'h0010_0093);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 32'h8000_0100, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
         checkOutput("bp_inst_valid_hold", 32'(inst_valid), 1);
         checkOutput("bp_inst_hold", inst, 32'h0010_0093);
         checkOutput("bp_inst_pc_hold", inst_pc, 32'h8000_0004);
      end
      applyStimulus(0, 32'h8000_0100, 0, 0, 0, 0, 0, 1);
      checkOutput("bp_wait_valid", 32'(inst_valid), 0);
      checkOutput("bp_ar_transfers", 32'(ar_count - a0), 1);
      checkOutput("bp_out_transfers", 32'(out_count - o0), 1);

      // Error response
      applyStimulus(0, 32'h8000_0008, 1, 1, 0, 0, 0, 0);
      checkOutput("err_araddr", araddr, 32'h8000_0008);
      applyStimulus(0, 32'h8000_0008, 0, 1, 0, 0, 0, 0);
      checkOutput("err_rready", 32'(rready), 1);
      applyStimulus(0, 32'h8000_0008, 0, 1, 1, 32'hDEAD_BEEF, 2'd2, 0);
      checkOutput("err_inst_valid", 32'(inst_valid), 1);
      checkOutput("err_inst_err", 32'(inst_err), 1);
      checkOutput("err_inst", inst, 32'hDEAD_BEEF);
      applyStimulus(0, 32'h8000_0008, 0, 1, 0, 0, 0, 1);

      // Misaligned pc never reaches the bus
      a0 = ar_count;
      applyStimulus(0, 32'h8000_0002, 1, 1, 0, 0, 0, 0);
      checkOutput("mis_arvalid", 32'(arvalid), 0);
      checkOutput("mis_inst_valid", 32'(inst_valid), 1);
      checkOutput("mis_inst_err", 32'(inst_err), 1);
      checkOutput("mis_inst", inst, 0);
      checkOutput("mis_inst_pc", inst_pc, 32'h8000_0002);
      applyStimulus(0, 32'h8000_0002, 0, 1, 0, 0, 0, 1);
      checkOutput("mis_wait_valid", 32'(inst_valid), 0);
      checkOutput("mis_no_ar", 32'(ar_count - a0), 0);

      // Two fetch_en pulses during R collapse into one later fetch
      applyStimulus(0, 32'h8000_000C, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h8000_000C, 0, 1, 0, 0, 0, 0);
      checkOutput("early_rready", 32'(rready), 1);
      a0 = ar_count;
      applyStimulus(0, 32'h8000_000C, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h8000_000C, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h8000_000C, 1, 1, 0, 0, 0, 0);
      checkOutput("early_still_r", 32'(rready), 1);
      applyStimulus(0, 32'h8000_0010, 0, 1, 1, 32'h0000_0513, 0, 0);
      checkOutput("early_inst", inst, 32'h0000_0513);
      applyStimulus(0, 32'h8000_0010, 0, 1, 0, 0, 0, 1);
      checkOutput("early_wait_arvalid", 32'(arvalid), 0);
      applyStimulus(0, 32'h8000_0010, 0, 1, 0, 0, 0, 0);
      checkOutput("early_arvalid", 32'(arvalid), 1);
      checkOutput("early_araddr", araddr, 32'h8000_0010);
      applyStimulus(0, 32'h8000_0010, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h8000_0010, 0, 1, 1, 32'h0000_0613, 0, 0);
      checkOutput("early_inst2", inst, 32'h0000_0613);
      applyStimulus(0, 32'h8000_0010, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 32'h8000_0010, 0, 1, 0, 0, 0, 0);
         checkOutput("early_idle_arvalid", 32'(arvalid), 0);
      end
      checkOutput("early_one_ar", 32'(ar_count - a0), 1);

      // Reset while in R, then a stray rvalid
      applyStimulus(0, 32'h8000_0014, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h8000_0014, 0, 1, 0, 0, 0, 0);
      checkOutput("rr_rready", 32'(rready), 1);
      applyStimulus(1, 32'h8000_0014, 0, 1, 0, 0, 0, 0);
      checkOutput("rr_rst_rready", 32'(rready), 0);
      checkOutput("rr_rst_araddr", araddr, 0);
      checkOutput("rr_rst_valid", 32'(inst_valid), 0);
      applyStimulus(0, 32'h8000_0018, 0, 0, 1, 32'h0BAD_F00D, 0, 0);
      checkOutput("rr_arvalid", 32'(arvalid), 1);
      checkOutput("rr_araddr", araddr, 32'h8000_0018);
      checkOutput("rr_inst_valid", 32'(inst_valid), 0);
      checkOutput("rr_rready_ar", 32'(rready), 0);
      applyStimulus(0, 32'h8000_0018, 0, 0, 1, 32'h0BAD_F00D, 0, 0);
      checkOutput("rr_arvalid_hold", 32'(arvalid), 1);
      checkOutput("rr_inst_valid_hold", 32'(inst_valid), 0);
      applyStimulus(0, 32'h8000_0018, 0, 1, 0, 0, 0, 0);
      checkOutput("rr_inst_valid_r", 32'(inst_valid), 0);
      applyStimulus(0, 32'h8000_0018, 0, 1, 1, 32'h0000_0713, 0, 0);
      checkOutput("rr_final_valid", 32'(inst_valid), 1);
      checkOutput("rr_final_inst", inst, 32'h0000_0713);
      checkOutput("rr_final_pc", inst_pc, 32'h8000_0018);
      applyStimulus(0, 32'h8000_0018, 0, 1, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
